regfile_wb_sched: RTL and testbench

//  Writeback scheduler for the 12-port VLIW register file (4 write ports: 3/6/9/12).

---
 rtl/regfile_wb_sched.sv | 157 +++++++++++++++
 tb/tb_regfile_wb_sched.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler: four per-lane result FIFOs that drive the four regfile write ports.
// Same-register heads are serialized lowest-lane-first so that bundle order holds on WAW.
module regfile_wb_sched #(
  parameter int XLEN        = 32,
  parameter int E_SUPPORTED = 0,
  parameter int DEPTH       = 2,
  localparam int NUMREGS    = (E_SUPPORTED == 1) ? 16 : 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                WBValidE,
  output logic [3:0]                WBReadyE,
  input  logic [3:0][4:0]           WBRdE,
  input  logic [3:0][XLEN-1:0]      WBDataE,
  input  logic                      WBStall,
  input  logic                      Flush,
  output logic [3:0]                RFWe,
  output logic [3:0][4:0]           RFA,
  output logic [3:0][XLEN-1:0]      RFWd,
  output logic [NUMREGS-1:0]        PendingW,
  output logic                      IllegalRd
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [5:0] NUMREGS_W = 6'(NUMREGS);

  logic [4:0]      mem_rd   [4][DEPTH];
  logic [XLEN-1:0] mem_data [4][DEPTH];
  logic [PW-1:0]   wptr [4];
  logic [PW-1:0]   rptr [4];
  logic [CW-1:0]   cnt  [4];

  logic [3:0]      accept_p0;
  logic [3:0]      legal_p0;
  logic [3:0]      store_p0;
  logic            illegal_p0;
  logic            illegal_p1;

  logic [4:0]      head_rd_p0   [4];
  logic [XLEN-1:0] head_data_p0 [4];
  logic [3:0]      nonempty_p0;
  logic [3:0]      elig_p0;
  logic [3:0]      blocked_p0;
  logic [3:0]      grant_p0;
  logic            entry_vld_p0 [4][DEPTH];
  logic [PW-1:0]   off_p0;

  // Stage p0: enqueue qualification; illegal destinations are consumed but never stored.
  always_comb begin
    accept_p0  = '0;
    legal_p0   = '0;
    store_p0   = '0;
    illegal_p0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      WBReadyE[i]  = (cnt[i] < CW'(DEPTH));
      accept_p0[i] = WBValidE[i] && WBReadyE[i];
      legal_p0[i]  = ({1'b0, WBRdE[i]} < NUMREGS_W);
      store_p0[i]  = accept_p0[i] && legal_p0[i] && !Flush;
      if (accept_p0[i] && !legal_p0[i] && !Flush)
        illegal_p0 = 1'b1;
    end
  end

  // Stage p0: head selection and same-register arbitration, lowest lane wins.
  always_comb begin
    blocked_p0 = '0;
    grant_p0   = '0;
    for (int i = 0; i < 4; i++) begin
      head_rd_p0[i]   = mem_rd[i][rptr[i]];
      head_data_p0[i] = mem_data[i][rptr[i]];
      nonempty_p0[i]  = (cnt[i] != '0);
      elig_p0[i]      = nonempty_p0[i] && !WBStall && !Flush;
    end
    for (int i = 1; i < 4; i++) begin
      for (int j = 0; j < i; j++) begin
        if (elig_p0[j] && (head_rd_p0[j] == head_rd_p0[i]) && (head_rd_p0[i] != 5'd0))
          blocked_p0[i] = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++)
      grant_p0[i] = elig_p0[i] && !blocked_p0[i];
  end

  // An x0 head still pops on grant, it just never raises a write enable.
  always_comb begin
    RFWe = '0;
    RFA  = '0;
    RFWd = '0;
    for (int i = 0; i < 4; i++) begin
      RFWe[i] = grant_p0[i] && (head_rd_p0[i] != 5'd0);
      RFA[i]  = nonempty_p0[i] ? head_rd_p0[i] : 5'd0;
      RFWd[i] = nonempty_p0[i] ? head_data_p0[i] : '0;
    end
  end

  always_comb begin
    off_p0 = '0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        off_p0             = PW'(k) - rptr[i];
        entry_vld_p0[i][k] = ({1'b0, off_p0} < cnt[i]);
      end
    end
  end

  always_comb begin
    PendingW = '0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        for (int r = 1; r < NUMREGS; r++) begin
          if (entry_vld_p0[i][k] && (mem_rd[i][k] == 5'(r)))
            PendingW[r] = 1'b1;
        end
      end
    end
  end

  // Stage p1: FIFO control state; Flush overrides every push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_p1 <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt[i]  <= '0;
        wptr[i] <= '0;
        rptr[i] <= '0;
      end
    end else begin
      illegal_p1 <= illegal_p0;
      for (int i = 0; i < 4; i++) begin
        if (Flush) begin
          cnt[i]  <= '0;
          wptr[i] <= '0;
          rptr[i] <= '0;
        end else begin
          if (store_p0[i])
            wptr[i] <= wptr[i] + PW'(1);
          if (grant_p0[i])
            rptr[i] <= rptr[i] + PW'(1);
          cnt[i] <= cnt[i] + CW'(store_p0[i]) - CW'(grant_p0[i]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (store_p0[i]) begin
        mem_rd[i][wptr[i]]   <= WBRdE[i];
        mem_data[i][wptr[i]] <= WBDataE[i];
      end
    end
  end

  assign IllegalRd = illegal_p1;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: a 32-register instance backed by a negedge
// regfile model, plus a 16-register instance for illegal destination handling.
module tb_regfile_wb_sched;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0]       a_valid, a_ready, a_we;
  logic [3:0][4:0]  a_rd, a_ra;
  logic [3:0][31:0] a_data, a_wd;
  logic             a_stall, a_flush, a_ill;
  logic [31:0]      a_pend;

  logic [3:0]       e_valid, e_ready, e_we;
  logic [3:0][4:0]  e_rd, e_ra;
  logic [3:0][31:0] e_data, e_wd;
  logic             e_stall, e_flush, e_ill;
  logic [15:0]      e_pend;

  regfile_wb_sched #(.XLEN(32), .E_SUPPORTED(0), .DEPTH(2)) dut_a (
    .clk(clk), .reset(reset), .WBValidE(a_valid), .WBReadyE(a_ready), .WBRdE(a_rd),
    .WBDataE(a_data), .WBStall(a_stall), .Flush(a_flush), .RFWe(a_we), .RFA(a_ra),
    .RFWd(a_wd), .PendingW(a_pend), .IllegalRd(a_ill));

  regfile_wb_sched #(.XLEN(32), .E_SUPPORTED(1), .DEPTH(2)) dut_e (
    .clk(clk), .reset(reset), .WBValidE(e_valid), .WBReadyE(e_ready), .WBRdE(e_rd),
    .WBDataE(e_data), .WBStall(e_stall), .Flush(e_flush), .RFWe(e_we), .RFA(e_ra),
    .RFWd(e_wd), .PendingW(e_pend), .IllegalRd(e_ill));

  // Regfile model: captures enabled write ports on the falling edge.
  logic [31:0] rf [32];
  logic        rf_clr;
  always @(negedge clk) begin
    if (rf_clr) begin
      for (int r = 0; r < 32; r++) rf[r] <= 32'h0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (a_we[i]) rf[a_ra[i]] <= a_wd[i];
    end
  end

  int n_asrt = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; rf_clr = 1'b1;
    a_valid = '0; a_rd = '0; a_data = '0; a_stall = 1'b0; a_flush = 1'b0;
    e_valid = '0; e_rd = '0; e_data = '0; e_stall = 1'b0; e_flush = 1'b0;
    step(); step();
    chk("rst_we", a_we, 0);
    chk("rst_ra", a_ra, 0);
    chk("rst_wd", a_wd, 0);
    chk("rst_pend", a_pend, 0);
    chk("rst_ill", a_ill, 0);
    chk("rst_ready", a_ready, 4'hF);
    chk("rst_e_ready", e_ready, 4'hF);
    chk("rst_e_pend", e_pend, 0);
    rf_clr = 1'b0;
    reset  = 1'b0;

    // 1: four independent writes in one bundle
    a_valid = 4'hF;
    a_rd[0] = 5'd1; a_rd[1] = 5'd2; a_rd[2] = 5'd3; a_rd[3] = 5'd4;
    a_data[0] = 32'hAAAA0001; a_data[1] = 32'hBBBB0002;
    a_data[2] = 32'hCCCC0003; a_data[3] = 32'hDDDD0004;
    step();
    a_valid = '0;
    chk("t1_we", a_we, 4'hF);
    chk("t1_ra3", a_ra[3], 5'd4);
    chk("t1_wd2", a_wd[2], 32'hCCCC0003);
    chk("t1_pend", a_pend, 32'h0000001E);
    step();
    chk("t1_we_after", a_we, 4'h0);
    chk("t1_pend_after", a_pend, 0);
    chk("t1_x1", rf[1], 32'hAAAA0001);
    chk("t1_x2", rf[2], 32'hBBBB0002);
    chk("t1_x3", rf[3], 32'hCCCC0003);
    chk("t1_x4", rf[4], 32'hDDDD0004);

    // 2: WAW conflict on x5 between lanes 0 and 2
    a_valid = 4'b0101;
    a_rd[0] = 5'd5; a_rd[2] = 5'd5;
    a_data[0] = 32'h11; a_data[2] = 32'h22;
    step();
    a_valid = '0;
    chk("t2_we_c1", a_we, 4'b0001);
    chk("t2_wd0_c1", a_wd[0], 32'h11);
    chk("t2_ra2_held", a_ra[2], 5'd5);
    chk("t2_wd2_held", a_wd[2], 32'h22);
    chk("t2_pend_c1", a_pend, 32'h00000020);
    step();
    chk("t2_we_c2", a_we, 4'b0100);
    chk("t2_x5_mid", rf[5], 32'h11);
    step();
    chk("t2_we_c3", a_we, 4'b0000);
    chk("t2_x5_final", rf[5], 32'h22);
    chk("t2_pend_c3", a_pend, 0);

    // 3: lane 1 fills under stall; third entry waits at the source
    a_stall = 1'b1;
    a_valid = 4'b0010; a_rd[1] = 5'd7; a_data[1] = 32'h71;
    #1 chk("t3_ready_e0", a_ready[1], 1'b1);
    step();
    chk("t3_ready_e1", a_ready[1], 1'b1);
    a_rd[1] = 5'd8; a_data[1] = 32'h72;
    step();
    chk("t3_ready_full", a_ready, 4'b1101);
    a_rd[1] = 5'd9; a_data[1] = 32'h73;
    step();
    chk("t3_ready_held", a_ready[1], 1'b0);
    chk("t3_pend", a_pend, 32'h00000180);
    chk("t3_we_stall", a_we, 4'h0);
    a_stall = 1'b0;
    #1 chk("t3_we_rel", a_we, 4'b0010);
    chk("t3_ra_rel", a_ra[1], 5'd7);
    step();
    chk("t3_ready_reopen", a_ready[1], 1'b1);
    chk("t3_ra_2nd", a_ra[1], 5'd8);
    step();
    a_valid = '0;
    chk("t3_ra_3rd", a_ra[1], 5'd9);
    chk("t3_we_3rd", a_we, 4'b0010);
    chk("t3_x7", rf[7], 32'h71);
    chk("t3_x8", rf[8], 32'h72);
    step();
    chk("t3_x9", rf[9], 32'h73);
    chk("t3_we_done", a_we, 4'h0);
    chk("t3_pend_done", a_pend, 0);

    // 4: stall with two entries per lane, then drain
    a_stall = 1'b1;
    a_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      a_rd[i] = 5'(10 + i); a_data[i] = 32'hA0 + 32'(i);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      a_rd[i] = 5'(14 + i); a_data[i] = 32'hB0 + 32'(i);
    end
    step();
    a_valid = '0;
    chk("t4_ready_full", a_ready, 4'h0);
    step(); step(); step();
    chk("t4_we_stall", a_we, 4'h0);
    chk("t4_pend_stall", a_pend, 32'h0003FC00);
    a_stall = 1'b0;
    #1 chk("t4_we_d1", a_we, 4'hF);
    chk("t4_ra0_d1", a_ra[0], 5'd10);
    step();
    chk("t4_we_d2", a_we, 4'hF);
    chk("t4_ra0_d2", a_ra[0], 5'd14);
    chk("t4_pend_d2", a_pend, 32'h0003C000);
    step();
    chk("t4_we_done", a_we, 4'h0);
    chk("t4_pend_done", a_pend, 0);
    chk("t4_x10", rf[10], 32'hA0);
    chk("t4_x17", rf[17], 32'hB3);

    // 5: 16-register instance drops rd=20, x0 head pops silently
    e_valid = 4'b1011;
    e_rd[0] = 5'd15; e_data[0] = 32'h15;
    e_rd[1] = 5'd0;  e_data[1] = 32'h99;
    e_rd[3] = 5'd20; e_data[3] = 32'h20;
    step();
    e_valid = '0;
    chk("t5_ill", e_ill, 1'b1);
    chk("t5_we", e_we, 4'b0001);
    chk("t5_pend", e_pend, 16'h8000);
    chk("t5_ready", e_ready, 4'hF);
    step();
    chk("t5_ill_clr", e_ill, 1'b0);
    chk("t5_we_clr", e_we, 4'h0);
    chk("t5_pend_clr", e_pend, 0);

    // 6: flush full FIFOs, then reset in the middle of a drain
    a_stall = 1'b1;
    a_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      a_rd[i] = 5'(20 + i); a_data[i] = 32'hC0 + 32'(i);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      a_rd[i] = 5'(24 + i); a_data[i] = 32'hC4 + 32'(i);
    end
    step();
    a_valid = '0;
    chk("t6_ready_full", a_ready, 4'h0);
    a_stall = 1'b0;
    a_flush = 1'b1;
    #1 chk("t6_we_flush", a_we, 4'h0);
    step();
    a_flush = 1'b0;
    chk("t6_ready_flushed", a_ready, 4'hF);
    chk("t6_pend_flushed", a_pend, 0);
    chk("t6_we_flushed", a_we, 4'h0);
    chk("t6_x20", rf[20], 0);
    chk("t6_x27", rf[27], 0);
    a_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      a_rd[i] = 5'(28 + i); a_data[i] = 32'hD0 + 32'(i);
    end
    step();
    a_valid = '0;
    chk("t6_we_predrain", a_we, 4'hF);
    reset = 1'b1;
    #1;
    chk("t6_rst_we", a_we, 4'h0);
    chk("t6_rst_ra", a_ra, 0);
    chk("t6_rst_wd", a_wd, 0);
    chk("t6_rst_pend", a_pend, 0);
    chk("t6_rst_ready", a_ready, 4'hF);
    #10;
    chk("t6_x28", rf[28], 0);
    chk("t6_x31", rf[31], 0);
    reset = 1'b0;
    step();
    chk("t6_post_ready", a_ready, 4'hF);
    chk("t6_post_we", a_we, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
